// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, register offsets and tap-index table for timer_bank.
package timer_pkg;
    typedef enum logic {T_RUN, T_RELOAD} timer_state_t;
    localparam int OFF_COUNT = 1;
    localparam int OFF_MOD = 2;
    localparam int OFF_CTRL = 3;
    localparam int STRIDE = 3;
    // div bit watched for CTRL[1:0] = 00, 01, 10, 11
    localparam int TAP_IDX [4] = '{9, 3, 5, 7};
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one count/modulo/control channel with tap edge detector and overflow reload FSM.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             we_count,
    input  logic             we_mod,
    input  logic             we_ctrl,
    input  logic [CNT_W-1:0] wdata,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] modulo,
    output logic [2:0]       ctrl,
    output logic             irq
);
    timer_state_t state, state_n;
    logic [CNT_W-1:0] count_n;
    logic [3:0] taps;
    logic s, s_prev, tick;

    assign taps = {div[TAP_IDX[3]], div[TAP_IDX[2]], div[TAP_IDX[1]], div[TAP_IDX[0]]};
    assign s = ctrl[2] & taps[ctrl[1:0]];
    // any falling s counts, whether from the divider, a DIV clear or a CTRL change
    assign tick = s_prev & ~s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= T_RUN;
            count  <= '0;
            modulo <= '0;
            ctrl   <= '0;
            s_prev <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            s_prev <= s;
            if (we_mod) modulo <= wdata;
            if (we_ctrl) ctrl <= wdata[2:0];
        end
    end

    always_comb begin
        state_n = T_RUN;
        count_n = count;
        irq     = 1'b0;
        if (state == T_RELOAD) begin
            irq     = ~we_count;
            count_n = (we_count || we_mod) ? wdata : modulo;
        end else if (we_count) begin
            count_n = wdata;
        end else if (tick) begin
            count_n = count + 1'b1;
            state_n = (&count) ? T_RELOAD : T_RUN;
        end
    end
endmodule

// File: rtl/timer_bank.sv
// timer_bank: shared free-running divider, register decode and NUM_TIMERS timer channels.
module timer_bank
    import timer_pkg::*;
#(
    parameter int NUM_TIMERS = 1,
    parameter int CNT_W = 8,
    parameter int DIV_W = 16,
    parameter int ADDR_W = $clog2(1 + 3 * NUM_TIMERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    input  logic [CNT_W-1:0]      wdata,
    output logic [CNT_W-1:0]      rdata,
    output logic [NUM_TIMERS-1:0] irq
);
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] count [NUM_TIMERS];
    logic [CNT_W-1:0] modulo [NUM_TIMERS];
    logic [2:0] ctrl [NUM_TIMERS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div <= '0;
        else if (we && addr == '0) div <= '0;
        else div <= div + 1'b1;
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        timer_channel #(.CNT_W(CNT_W), .DIV_W(DIV_W)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .div      (div),
            .we_count (we && addr == ADDR_W'(OFF_COUNT + STRIDE * i)),
            .we_mod   (we && addr == ADDR_W'(OFF_MOD + STRIDE * i)),
            .we_ctrl  (we && addr == ADDR_W'(OFF_CTRL + STRIDE * i)),
            .wdata    (wdata),
            .count    (count[i]),
            .modulo   (modulo[i]),
            .ctrl     (ctrl[i]),
            .irq      (irq[i])
        );
    end

    always_comb begin
        rdata = (addr == '0) ? div[DIV_W-1 -: CNT_W] : '0;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (addr == ADDR_W'(OFF_COUNT + STRIDE * i)) rdata = count[i];
            if (addr == ADDR_W'(OFF_MOD + STRIDE * i)) rdata = modulo[i];
            if (addr == ADDR_W'(OFF_CTRL + STRIDE * i)) rdata = CNT_W'(ctrl[i]);
        end
    end
endmodule
